wb_dma_master: RTL and testbench

Single-channel Wishbone bus initiator that copies a block of 32-bit words from a source address to a destination address on the CPU-side Wishbone bus. Typical use is moving TPM command/response buffers between the TPM buffer RAM (0xF0000800) and DDR3 RAM (0x80000000) without CPU load. It drives the same classic Wishbone signals the CPU drives into the top-level decoder, and is arbitrated externally. It is programmed through a simple start/parameter port and reports completion, progress and errors.

---
 rtl/wb_dma_master.sv | 171 +++++++++++++++++
 tb/tb_wb_dma_master.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dma_master.sv
// Single-channel Wishbone initiator: copies len 32-bit words from src to dst,
// one read/write pair at a time, with bus-error, timeout and abort reporting.
module wb_dma_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned LEN_WIDTH      = 11,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clk,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  output logic [LEN_WIDTH-1:0]  words_done_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ErrNone  = 2'b00;
  localparam logic [1:0] ErrBus   = 2'b01;
  localparam logic [1:0] ErrTmo   = 2'b10;
  localparam logic [1:0] ErrAbort = 2'b11;

  typedef enum logic [2:0] {StIdle, StRd, StRdGap, StWr, StWrGap, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, words_q, words_d;
  logic [31:0]           buf_q, buf_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic                  tmo_hit;

  assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    words_d    = words_q;
    buf_d      = buf_q;
    err_code_d = err_code_q;
    tmo_d      = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          words_d    = '0;
          err_code_d = ErrNone;
          if (len_i != '0) begin
            src_d   = src_addr_i & ~ADDR_WIDTH'(3);
            dst_d   = dst_addr_i & ~ADDR_WIDTH'(3);
            len_d   = len_i;
            tmo_d   = '0;
            state_d = StRd;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRd: begin
        // Error beats abort beats ack; read data is dropped on abort.
        if (wb_err_i) begin
          err_code_d = ErrBus;
          state_d    = StDone;
        end else if (abort_i) begin
          err_code_d = ErrAbort;
          state_d    = StDone;
        end else if (wb_ack_i) begin
          buf_d   = wb_dat_i;
          state_d = StRdGap;
        end else if (tmo_hit) begin
          err_code_d = ErrTmo;
          state_d    = StDone;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StRdGap, StWrGap: begin
        if (abort_i) begin
          err_code_d = ErrAbort;
          state_d    = StDone;
        end else begin
          tmo_d   = '0;
          state_d = (state_q == StRdGap) ? StWr : StRd;
        end
      end
      StWr: begin
        if (wb_err_i) begin
          err_code_d = ErrBus;
          state_d    = StDone;
        end else if (wb_ack_i) begin
          // A write acked on the abort edge still counts.
          words_d = words_q + LEN_WIDTH'(1);
          src_d   = src_q + ADDR_WIDTH'(4);
          dst_d   = dst_q + ADDR_WIDTH'(4);
          if (abort_i) begin
            err_code_d = ErrAbort;
            state_d    = StDone;
          end else if (words_q + LEN_WIDTH'(1) == len_q) begin
            state_d = StDone;
          end else begin
            state_d = StWrGap;
          end
        end else if (abort_i) begin
          err_code_d = ErrAbort;
          state_d    = StDone;
        end else if (tmo_hit) begin
          err_code_d = ErrTmo;
          state_d    = StDone;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= StIdle;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      words_q    <= '0;
      buf_q      <= '0;
      err_code_q <= ErrNone;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      words_q    <= words_d;
      buf_q      <= buf_d;
      err_code_q <= err_code_d;
      tmo_q      <= tmo_d;
    end
  end

  // Outputs decode only registered state, never the slave termination inputs.
  assign busy_o       = (state_q == StRd) || (state_q == StRdGap) ||
                        (state_q == StWr) || (state_q == StWrGap);
  assign done_o       = (state_q == StDone);
  assign err_code_o   = err_code_q;
  assign err_o        = (err_code_q != ErrNone);
  assign words_done_o = words_q;
  assign wb_cyc_o     = (state_q == StRd) || (state_q == StWr);
  assign wb_stb_o     = wb_cyc_o;
  assign wb_we_o      = (state_q == StWr);
  assign wb_sel_o     = wb_cyc_o ? 4'hF : 4'h0;
  assign wb_dat_o     = buf_q;
  assign wb_adr_o     = (state_q == StRd) ? src_q :
                        (state_q == StWr) ? dst_q : '0;

endmodule

// File: tb/tb_wb_dma_master.sv
// Bench for wb_dma_master: behavioural Wishbone slave plus a scoreboard of
// expected bus transfers, checked as the DUT terminates each bus cycle.
module tb_wb_dma_master;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 11;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } txn_t;

  logic          wb_clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] src_addr_i = '0;
  logic [AW-1:0] dst_addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          abort_i = 1'b0;
  logic          busy_o, done_o, err_o;
  logic [1:0]    err_code_o;
  logic [LW-1:0] words_done_o;
  logic [AW-1:0] wb_adr_o;
  logic [31:0]   wb_dat_o;
  logic [31:0]   wb_dat_i = '0;
  logic          wb_we_o, wb_stb_o, wb_cyc_o;
  logic [3:0]    wb_sel_o;
  logic          wb_ack_i = 1'b0;
  logic          wb_err_i = 1'b0;

  int   vectors = 0;
  int   miscompares = 0;
  txn_t exp_q[$];
  bit   ack_en = 1'b1;
  int   err_wr_idx = -1;
  int   wr_idx = 0;
  int   stb_cnt = 0;
  int   done_cnt = 0;

  wb_dma_master #(
    .ADDR_WIDTH    (AW),
    .LEN_WIDTH     (LW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk      (wb_clk),
    .rstn_i      (rstn_i),
    .start_i     (start_i),
    .src_addr_i  (src_addr_i),
    .dst_addr_i  (dst_addr_i),
    .len_i       (len_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o),
    .words_done_o(words_done_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_dat_i    (wb_dat_i),
    .wb_we_o     (wb_we_o),
    .wb_sel_o    (wb_sel_o),
    .wb_stb_o    (wb_stb_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i)
  );

  always #5 wb_clk = ~wb_clk;

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  // Slave answers in the same cycle stb is seen; scoreboard checks each terminated cycle.
  always @(negedge wb_clk) begin
    txn_t e;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = '0;
    if (done_o === 1'b1) done_cnt++;
    if (wb_cyc_o === 1'b1) begin
      vectors++;
      if (wb_stb_o !== 1'b1 || wb_sel_o !== 4'hF) begin
        miscompares++;
        $display("FAIL bus_signals: stb=%b sel=%h, required stb=1 sel=f", wb_stb_o, wb_sel_o);
      end
    end
    if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1) begin
      stb_cnt++;
      if (ack_en) begin
        if (wb_we_o && wr_idx == err_wr_idx) begin
          wb_err_i = 1'b1;
        end else begin
          wb_ack_i = 1'b1;
          if (!wb_we_o) wb_dat_i = rd_data(wb_adr_o);
        end
        if (wb_we_o) wr_idx++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_cycle: adr=%h we=%b, required no bus cycle", wb_adr_o, wb_we_o);
        end else begin
          e = exp_q.pop_front();
          if (wb_adr_o !== e.adr || wb_we_o !== e.we || (e.we && wb_dat_o !== e.dat)) begin
            miscompares++;
            $display("FAIL bus_txn: adr=%h we=%b dat=%h, required adr=%h we=%b dat=%h",
                     wb_adr_o, wb_we_o, wb_dat_o, e.adr, e.we, e.dat);
          end
        end
      end
    end
  end

  task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
    for (int i = 0; i < len; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = src + 32'(4 * i);
      b = dst + 32'(4 * i);
      exp_q.push_back('{adr: a, we: 1'b0, dat: 32'h0});
      exp_q.push_back('{adr: b, we: 1'b1, dat: rd_data(a)});
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1 with start_i low again.
  task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst, input int len);
    src_addr_i = src;
    dst_addr_i = dst;
    len_i      = LW'(len);
    start_i    = 1'b1;
    @(posedge wb_clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles <= bound) begin
      if (done_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge wb_clk); #1;
      cycles++;
    end
  endtask

  task automatic reset_counters();
    stb_cnt  = 0;
    done_cnt = 0;
    wr_idx   = 0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({busy_o, done_o, err_o, err_code_o, wb_we_o, wb_stb_o, wb_cyc_o} !== 8'h0 ||
        words_done_o !== '0 || wb_adr_o !== '0 || wb_dat_o !== '0 || wb_sel_o !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b code=%b cyc=%b adr=%h dat=%h, required all 0",
               busy_o, done_o, err_o, err_code_o, wb_cyc_o, wb_adr_o, wb_dat_o);
    end
    repeat (2) @(posedge wb_clk);
    #1 rstn_i = 1'b1;
    @(posedge wb_clk); #1;
    vectors++;
    if (busy_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: busy=%b cyc=%b, required 0 0", busy_o, wb_cyc_o);
    end
  endtask

  task automatic test_copy3();
    int cycles;
    bit ok;
    reset_counters();
    push_copy(32'h8000_0000, 32'hF000_0800, 3);
    start_xfer(32'h8000_0000, 32'hF000_0800, 3);
    vectors++;
    if (wb_cyc_o !== 1'b1 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL start_latency: cyc=%b busy=%b, required 1 1", wb_cyc_o, busy_o);
    end
    wait_done(100, cycles, ok);
    vectors++;
    if (!ok || cycles != 11) begin
      miscompares++;
      $display("FAIL copy3_done_time: seen=%b cycles=%0d, required seen=1 cycles=11", ok, cycles);
    end
    repeat (2) @(posedge wb_clk); #1;
    vectors++;
    if (done_cnt != 1 || words_done_o !== LW'(3) || err_o !== 1'b0 || stb_cnt != 6 ||
        exp_q.size() != 0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL copy3_result: done=%0d words=%0d err=%b stb=%0d left=%0d, required 1 3 0 6 0",
               done_cnt, words_done_o, err_o, stb_cnt, exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    int cycles;
    bit ok;
    reset_counters();
    start_xfer(32'h8000_0000, 32'hF000_0800, 0);
    wait_done(5, cycles, ok);
    vectors++;
    if (!ok || cycles != 0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len_done: seen=%b cycles=%0d busy=%b, required 1 0 0", ok, cycles, busy_o);
    end
    repeat (2) @(posedge wb_clk); #1;
    vectors++;
    if (stb_cnt != 0 || words_done_o !== '0 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL zero_len_result: stb=%0d words=%0d done=%0d, required 0 0 1",
               stb_cnt, words_done_o, done_cnt);
    end
  endtask

  task automatic test_slave_err();
    int cycles;
    bit ok;
    reset_counters();
    err_wr_idx = 1;
    push_copy(32'h8000_0100, 32'hF000_0900, 3);
    start_xfer(32'h8000_0100, 32'hF000_0900, 3);
    wait_done(100, cycles, ok);
    repeat (2) @(posedge wb_clk); #1;
    vectors++;
    if (!ok || err_code_o !== 2'b01 || err_o !== 1'b1 || words_done_o !== LW'(1) ||
        done_cnt != 1 || wb_cyc_o !== 1'b0 || exp_q.size() != 2) begin
      miscompares++;
      $display("FAIL slave_err: seen=%b code=%b err=%b words=%0d done=%0d cyc=%b left=%0d, required 1 01 1 1 1 0 2",
               ok, err_code_o, err_o, words_done_o, done_cnt, wb_cyc_o, exp_q.size());
    end
    exp_q.delete();
    err_wr_idx = -1;
    reset_counters();
    push_copy(32'h8000_0200, 32'hF000_0A00, 1);
    start_xfer(32'h8000_0200, 32'hF000_0A00, 1);
    vectors++;
    if (err_o !== 1'b0 || err_code_o !== 2'b00 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL err_clear: err=%b code=%b busy=%b, required 0 00 1", err_o, err_code_o, busy_o);
    end
    wait_done(50, cycles, ok);
    repeat (2) @(posedge wb_clk); #1;
    vectors++;
    if (!ok || words_done_o !== LW'(1) || err_o !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL after_err_copy: seen=%b words=%0d err=%b left=%0d, required 1 1 0 0",
               ok, words_done_o, err_o, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int cycles;
    bit ok;
    reset_counters();
    ack_en = 1'b0;
    push_copy(32'h8000_0300, 32'hF000_0B00, 1);
    start_xfer(32'h8000_0300, 32'hF000_0B00, 1);
    wait_done(50, cycles, ok);
    repeat (2) @(posedge wb_clk); #1;
    vectors++;
    if (!ok || stb_cnt != 8 || err_code_o !== 2'b10 || done_cnt != 1 || words_done_o !== '0) begin
      miscompares++;
      $display("FAIL timeout: seen=%b stb=%0d code=%b done=%0d words=%0d, required 1 8 10 1 0",
               ok, stb_cnt, err_code_o, done_cnt, words_done_o);
    end
    exp_q.delete();
    ack_en = 1'b1;
  endtask

  task automatic test_abort();
    bit seen_wr;
    reset_counters();
    seen_wr = 1'b0;
    push_copy(32'h8000_0400, 32'hF000_0C00, 3);
    src_addr_i = 32'h8000_0400;
    dst_addr_i = 32'hF000_0C00;
    len_i      = LW'(3);
    start_i    = 1'b1;
    // start_i stays high throughout the busy period and must be ignored.
    for (int i = 0; i < 20; i++) begin
      @(posedge wb_clk); #1;
      if (wb_we_o === 1'b1 && wb_stb_o === 1'b1) begin
        seen_wr = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen_wr) begin
      miscompares++;
      $display("FAIL abort_wait_write: seen=0, required 1");
    end
    abort_i = 1'b1;
    @(posedge wb_clk); #1;
    abort_i = 1'b0;
    start_i = 1'b0;
    vectors++;
    if (done_o !== 1'b1 || words_done_o !== LW'(1) || err_code_o !== 2'b11 || wb_cyc_o !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_edge: done=%b words=%0d code=%b cyc=%b, required 1 1 11 0",
               done_o, words_done_o, err_code_o, wb_cyc_o);
    end
    repeat (4) @(posedge wb_clk); #1;
    vectors++;
    if (stb_cnt != 2 || done_cnt != 1 || busy_o !== 1'b0 || exp_q.size() != 4) begin
      miscompares++;
      $display("FAIL abort_after: stb=%0d done=%0d busy=%b left=%0d, required 2 1 0 4",
               stb_cnt, done_cnt, busy_o, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    int cycles;
    bit ok;
    reset_counters();
    push_copy(32'hFFFF_FFFC, 32'h0000_2000, 2);
    start_xfer(32'hFFFF_FFFC, 32'h0000_2000, 2);
    wait_done(100, cycles, ok);
    repeat (2) @(posedge wb_clk); #1;
    vectors++;
    if (!ok || words_done_o !== LW'(2) || err_o !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL wrap: seen=%b words=%0d err=%b left=%0d, required 1 2 0 0",
               ok, words_done_o, err_o, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    reset_counters();
    ack_en = 1'b0;
    push_copy(32'h8000_0500, 32'hF000_0D00, 1);
    start_xfer(32'h8000_0500, 32'hF000_0D00, 1);
    @(negedge wb_clk); #2;
    rstn_i = 1'b0;
    #1;
    vectors++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: cyc=%b stb=%b busy=%b, required 0 0 0", wb_cyc_o, wb_stb_o, busy_o);
    end
    @(posedge wb_clk); #1;
    rstn_i = 1'b1;
    exp_q.delete();
    ack_en = 1'b1;
    @(posedge wb_clk); #1;
    vectors++;
    if (busy_o !== 1'b0 || words_done_o !== '0 || err_code_o !== 2'b00) begin
      miscompares++;
      $display("FAIL after_async_reset: busy=%b words=%0d code=%b, required 0 0 00",
               busy_o, words_done_o, err_code_o);
    end
  endtask

  initial begin
    test_reset();
    test_copy3();
    test_zero_len();
    test_slave_err();
    test_timeout();
    test_abort();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
